// File: rtl/rle_pkg.sv
// Shared definitions for the run-length decoder: FSM state encoding,
// default geometry and code-word field helpers.
// Optional feature macro used by the decoder: RLE_ERR_CHECK_EN.
package rle_pkg;

   localparam int RLE_DATA_W     = 8;
   localparam int RLE_RUN_W      = 8;
   localparam int RLE_ADDR_W     = 16;
   localparam int RLE_IMG_PIXELS = 784;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      EXPAND   = 3'd2,
      DONE     = 3'd3,
      WAIT_LOW = 3'd4
   } rle_state_e;

   // Code words are {run, pixel}; callers widen the word to 64 bits and
   // narrow the result back to the field width with a size cast.
   function automatic logic [63:0] code_run(input logic [63:0] word,
                                            input int          data_w,
                                            input int          run_w);
      return (word >> data_w) & ((64'd1 << run_w) - 64'd1);
   endfunction

   function automatic logic [63:0] code_pix(input logic [63:0] word,
                                            input int          data_w);
      return word & ((64'd1 << data_w) - 64'd1);
   endfunction

endpackage

// File: rtl/rle_run_counter.sv
// Loadable down-counter holding the pixels still owed by the current run.
// zero is high when nothing remains beyond the write already issued.
module rle_run_counter
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   // Load takes priority over decrement; decrement saturates at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/rle_decompressor.sv
// Run-length decoder feeding the CNN image buffer. Each accepted code word
// {run, pixel} expands into `run` sequential pixel writes until IMG_PIXELS
// pixels have been written, then a one-cycle done pulse is issued.
// Optional feature: define RLE_ERR_CHECK_EN to add the sticky decomp_err
// output (zero-run word accepted, or run truncated at the image end).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | pixel counter cleared, waiting for decompressor_en
// FETCH    | in_ready high, waiting for a code word
// EXPAND   | a registered pixel write is on the memory port this cycle
// DONE     | decompressor_done high for this one cycle
// WAIT_LOW | image finished, waiting for decompressor_en to drop
module rle_decompressor
   import rle_pkg::*;
#(
   parameter int DATA_W     = RLE_DATA_W,
   parameter int RUN_W      = RLE_RUN_W,
   parameter int ADDR_W     = RLE_ADDR_W,
   parameter int IMG_PIXELS = RLE_IMG_PIXELS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    decompressor_en,
   input  logic                    in_valid,
   input  logic [RUN_W+DATA_W-1:0] in_data,
   output logic                    in_ready,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   output logic                    decompressor_done
`ifdef RLE_ERR_CHECK_EN
   ,
   output logic                    decomp_err
`endif
);

   // One extra bit so the count of issued pixels can reach IMG_PIXELS.
   localparam int               CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMG_PIXELS);

   rle_state_e        state;
   rle_state_e        state_next;
   logic [RUN_W-1:0]  run_field;
   logic [DATA_W-1:0] pix_field;
   logic [DATA_W-1:0] pix_hold;
   logic [CNT_W-1:0]  pix_cnt;
   logic              accept;
   logic              issue_first;
   logic              issue_next;
   logic              run_zero;
   logic              last_out;

   assign run_field = RUN_W'(code_run(64'(in_data), DATA_W, RUN_W));
   assign pix_field = DATA_W'(code_pix(64'(in_data), DATA_W));

   // pix_cnt counts writes already issued, so while in EXPAND it equals
   // IMG_PIXELS exactly when the write on the port is the final pixel.
   assign last_out = (pix_cnt == LAST_CNT);

   assign in_ready          = (state == FETCH);
   assign decompressor_done = (state == DONE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and write-issue decisions.
   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      issue_first = 1'b0;
      issue_next  = 1'b0;
      case (state)
         IDLE: begin
            if (decompressor_en) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            if (!decompressor_en) begin
               state_next = IDLE;
            end else if (in_valid) begin
               accept = 1'b1;
               if (run_field != '0) begin
                  issue_first = 1'b1;
                  state_next  = EXPAND;
               end
            end
         end
         EXPAND: begin
            if (!decompressor_en) begin
               state_next = IDLE;
            end else if (last_out) begin
               state_next = DONE;
            end else if (run_zero) begin
               state_next = FETCH;
            end else begin
               issue_next = 1'b1;
            end
         end
         DONE: begin
            state_next = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!decompressor_en) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The first write of a run is issued from the accepting edge, so the
   // counter is loaded with what is still owed after that write.
   rle_run_counter #(
      .W (RUN_W)
   ) u_run_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (issue_first),
      .load_val (run_field - RUN_W'(1)),
      .dec      (issue_next),
      .zero     (run_zero)
   );

   // Pixel counter and registered memory port; address and data hold
   // their last values whenever no write is issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt   <= '0;
         pix_hold  <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= issue_first | issue_next;
         if (accept) begin
            pix_hold <= pix_field;
         end
         if (state == IDLE) begin
            pix_cnt <= '0;
         end else if (issue_first || issue_next) begin
            pix_cnt  <= pix_cnt + CNT_W'(1);
            mem_addr <= pix_cnt[ADDR_W-1:0];
         end
         if (issue_first) begin
            mem_wdata <= pix_field;
         end else if (issue_next) begin
            mem_wdata <= pix_hold;
         end
      end
   end

`ifdef RLE_ERR_CHECK_EN
   logic zero_run_hit;
   logic trunc_hit;

   assign zero_run_hit = accept && (run_field == '0);
   assign trunc_hit    = (state == EXPAND) && decompressor_en && last_out && !run_zero;

   // Sticky error; a fresh decode start clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         decomp_err <= 1'b0;
      end else if ((state == IDLE) && decompressor_en) begin
         decomp_err <= 1'b0;
      end else if (zero_run_hit || trunc_hit) begin
         decomp_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_rle_decompressor.sv
// Bench for rle_decompressor with a 16-pixel image.
module tb_rle_decompressor;
   import rle_pkg::*;

   localparam int DATA_W = 8;
   localparam int RUN_W  = 8;
   localparam int ADDR_W = 16;
   localparam int IMG    = 16;

   typedef logic [15:0] word_t;

   typedef struct {
      int    n;
      word_t w[4];
      int    exp_wr;
      int    exp_cyc;
      bit    exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        in_valid;
   word_t       in_data;
   logic        in_ready;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        done;
`ifdef RLE_ERR_CHECK_EN
   logic        decomp_err;
`endif

   always #5 clk = ~clk;

   rle_decompressor #(
      .DATA_W     (DATA_W),
      .RUN_W      (RUN_W),
      .ADDR_W     (ADDR_W),
      .IMG_PIXELS (IMG)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .decompressor_en   (en),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_ready          (in_ready),
      .mem_we            (mem_we),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .decompressor_done (done)
`ifdef RLE_ERR_CHECK_EN
      ,
      .decomp_err        (decomp_err)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc++;

   logic [15:0] got_addr[$];
   logic [7:0]  got_data[$];
   int          done_cnt = 0;
   int          done_cyc = 0;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         got_addr.push_back(mem_addr);
         got_data.push_back(mem_wdata);
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: walk the word list, emit pixels until the image is full.
   logic [7:0] exp_px[$];
   int         exp_cycles;
   bit         exp_err;
   logic [7:0] last_px = 8'h00;

   function automatic void model(input word_t w[$]);
      int n = 0;
      exp_px.delete();
      exp_cycles = 0;
      exp_err    = 1'b0;
      foreach (w[i]) begin
         int r = int'(w[i][15:8]);
         if (n == IMG) break;
         exp_cycles += 1;
         if (r == 0) exp_err = 1'b1;
         for (int k = 0; k < r; k++) begin
            if (n == IMG) begin
               exp_err = 1'b1;
               break;
            end
            exp_px.push_back(w[i][7:0]);
            n++;
            exp_cycles++;
         end
      end
   endfunction

   task automatic run_image(input word_t w[$], input bit gaps, input int stall,
                            input string tag, input bit hand, input int hw,
                            input int hc, input bit he);
      int idx       = 0;
      int budget    = 0;
      int en_cyc    = 0;
      int stall_bad = 0;
      en       = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      got_addr.delete();
      got_data.delete();
      done_cnt = 0;
      en = 1'b1;
      @(negedge clk);
      en_cyc = cyc;
      while (done_cnt == 0 && budget < 2000) begin
         if (budget < stall) begin
            in_valid = 1'b0;
            if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'(IMG - 1)
                || mem_wdata !== last_px) stall_bad++;
         end else if (idx < w.size() && !(gaps && $urandom_range(0, 2) == 0)) begin
            in_valid = 1'b1;
            in_data  = w[idx];
         end else begin
            in_valid = 1'b0;
            in_data  = word_t'($urandom);
         end
         if (in_valid && in_ready) idx++;
         @(negedge clk);
         budget++;
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      model(w);
      if (stall > 0) chk({tag, " stall hold"}, stall_bad, 0);
      chk({tag, " write count"}, got_data.size(), exp_px.size());
      for (int i = 0; i < got_data.size() && i < exp_px.size(); i++) begin
         chk({tag, " addr"}, got_addr[i], i);
         chk({tag, " data"}, got_data[i], exp_px[i]);
      end
      chk({tag, " done pulses"}, done_cnt, 1);
      if (!gaps) chk({tag, " done timing"}, done_cyc - en_cyc, exp_cycles + stall);
`ifdef RLE_ERR_CHECK_EN
      chk({tag, " err"}, decomp_err, exp_err);
      if (hand) chk({tag, " err table"}, decomp_err, he);
`endif
      if (hand) begin
         chk({tag, " writes table"}, got_data.size(), hw);
         chk({tag, " cycles table"}, done_cyc - en_cyc, hc);
      end
      if (exp_px.size() > 0) last_px = exp_px[exp_px.size() - 1];
   endtask

   vec_t  tbl[7];
   word_t q[$];

   initial begin
      int hold_rdy;
      int n_before;
      tbl[0] = '{2, '{16'h0AAA, 16'h0655, 16'h0000, 16'h0000}, 16, 18, 1'b0};
      tbl[1] = '{1, '{16'h1433, 16'h0000, 16'h0000, 16'h0000}, 16, 17, 1'b1};
      tbl[2] = '{1, '{16'h10FF, 16'h0000, 16'h0000, 16'h0000}, 16, 17, 1'b0};
      tbl[3] = '{2, '{16'h0077, 16'h1011, 16'h0000, 16'h0000}, 16, 18, 1'b1};
      tbl[4] = '{3, '{16'h050A, 16'h050B, 16'h060C, 16'h0000}, 16, 19, 1'b0};
      tbl[5] = '{1, '{16'hFFC3, 16'h0000, 16'h0000, 16'h0000}, 16, 17, 1'b1};
      tbl[6] = '{3, '{16'h0101, 16'h0002, 16'h0F03, 16'h0000}, 16, 19, 1'b1};

      rst      = 1'b1;
      en       = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      chk("reset in_ready", in_ready, 0);
      chk("reset mem_we", mem_we, 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset mem_wdata", mem_wdata, 0);
      chk("reset done", done, 0);
`ifdef RLE_ERR_CHECK_EN
      chk("reset err", decomp_err, 0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         q.delete();
         for (int j = 0; j < tbl[i].n; j++) q.push_back(tbl[i].w[j]);
         run_image(q, 1'b0, 0, $sformatf("table%0d", i), 1'b1,
                   tbl[i].exp_wr, tbl[i].exp_cyc, tbl[i].exp_err);
      end

      // Enable held high after done: no retrigger even with words on offer.
      in_valid = 1'b1;
      in_data  = 16'h0499;
      n_before = got_data.size();
      hold_rdy = 0;
      repeat (20) begin
         @(negedge clk);
         if (in_ready !== 1'b0) hold_rdy++;
      end
      in_valid = 1'b0;
      chk("hold writes", got_data.size(), n_before);
      chk("hold done", done_cnt, 1);
      chk("hold ready", hold_rdy, 0);

      // Five idle FETCH cycles before the first word.
      q.delete();
      q.push_back(16'h1042);
      run_image(q, 1'b0, 5, "stall", 1'b1, 16, 22, 1'b0);

      // Abort after four writes, then restart from address 0.
      en = 1'b0;
      repeat (2) @(negedge clk);
      got_addr.delete();
      got_data.delete();
      done_cnt = 0;
      en = 1'b1;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h0A5A;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort writes", got_data.size(), 4);
      chk("abort last addr", got_addr[got_addr.size() - 1], 3);
      chk("abort done", done_cnt, 0);
      chk("abort mem_we", mem_we, 0);
      chk("abort in_ready", in_ready, 0);
      q.delete();
      q.push_back(16'h106C);
      run_image(q, 1'b0, 0, "restart", 1'b1, 16, 17, 1'b0);

      // Reset in the middle of a run.
      en = 1'b0;
      repeat (2) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h0A3C;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre-reset mem_we", mem_we, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst mem_we", mem_we, 0);
      chk("midrst mem_addr", mem_addr, 0);
      chk("midrst mem_wdata", mem_wdata, 0);
      chk("midrst in_ready", in_ready, 0);
      chk("midrst done", done, 0);
`ifdef RLE_ERR_CHECK_EN
      chk("midrst err", decomp_err, 0);
`endif
      rst = 1'b0;
      @(negedge clk);
      chk("post-reset in_ready", in_ready, 1);
      chk("post-reset mem_we", mem_we, 0);
      en = 1'b0;
      @(negedge clk);
      last_px = 8'h00;

      // Randomized images with optional valid gaps, checked against the model.
      for (int t = 0; t < 25; t++) begin
         int nw;
         bit g;
         q.delete();
         nw = int'($urandom_range(1, 8));
         for (int j = 0; j < nw; j++) begin
            word_t wd;
            wd[15:8] = 8'($urandom_range(0, 8));
            wd[7:0]  = 8'($urandom);
            q.push_back(wd);
         end
         q.push_back({8'hFF, 8'($urandom)});
         g = 1'($urandom_range(0, 1));
         run_image(q, g, 0, $sformatf("rand%0d", t), 1'b0, 0, 0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/rle_decompressor.md
# rle_decompressor

Run-length decoder between the IO interface and the CNN image buffer. While `decompressor_en` is high it pulls compressed code words from the IO interface and expands each into a run of identical pixels written sequentially to image memory. After exactly `IMG_PIXELS` pixels it pulses `decompressor_done`, which hands control back to the DMA path.

## Interface
- `DATA_W`, 8: pixel width; low field of a code word.
- `RUN_W`, 8: run-length field width; high field of a code word.
- `ADDR_W`, 16: image memory address width.
- `IMG_PIXELS`, 784: pixels per image; must satisfy 1 ≤ `IMG_PIXELS` ≤ 2^`ADDR_W`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `decompressor_en` in 1: level enable from the IO controller.
- `in_valid` in 1: code word available.
- `in_data` in RUN_W+DATA_W: code word. `[RUN_W+DATA_W-1:DATA_W]` = run count, `[DATA_W-1:0]` = pixel value.
- `in_ready` out 1: decoder accepts a word this cycle.
- `mem_we` out 1: pixel write strobe.
- `mem_addr` out ADDR_W: pixel address, 0 to `IMG_PIXELS`-1.
- `mem_wdata` out DATA_W: pixel value.
- `decompressor_done` out 1: one-cycle completion pulse.
- `decomp_err` out 1: sticky format error; present only with `RLE_ERR_CHECK_EN`.

## Operation
- States: `IDLE`, `FETCH`, `EXPAND`, `DONE`, `WAIT_LOW`.
- `IDLE`:
  - Pixel counter is cleared to 0.
  - Goes to `FETCH` when `decompressor_en` = 1.
- `FETCH`:
  - `in_ready` = 1.
  - A word is accepted on a cycle where `in_valid & in_ready` are both high. On acceptance, pixel value and run count are latched.
  - Run count 0: the word is discarded, no writes occur, and the state stays `FETCH`.
  - Run count nonzero: go to `EXPAND`.
- `EXPAND`:
  - One pixel write per cycle: `mem_we` = 1, `mem_addr` = pixel counter, `mem_wdata` = latched value.
  - Pixel counter increments and the remaining run decrements.
  - If the write just made is pixel `IMG_PIXELS`-1, go to `DONE`. Any remaining run is truncated.
  - Otherwise, when the remaining run reaches 0, go to `FETCH`.
- `DONE`: `decompressor_done` = 1 for exactly one cycle, then go to `WAIT_LOW`.
- `WAIT_LOW`: hold until `decompressor_en` = 0, then go to `IDLE`. This stops a level-high enable from retriggering.
- Abort: `decompressor_en` = 0 in `FETCH` or `EXPAND` returns to `IDLE` on the next edge. No further writes occur and no done pulse is issued.
- Counter width is `ADDR_W`+1 bits so it cannot wrap before the `IMG_PIXELS` compare.
- A run count is unsigned; maximum run is 2^`RUN_W`-1.

## Timing
- Reset values: `in_ready` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `decompressor_done` = 0, `decomp_err` = 0. State resets to `IDLE`.
- `en` rising at edge N: `FETCH` is active from cycle N+1.
- Word accepted at edge M: first write occurs in cycle M+1.
- A run of n pixels occupies 1 fetch cycle plus n write cycles. Back-to-back words do not overlap.
- `in_ready` is asserted in `FETCH` only and depends only on state, with no combinational path from `in_valid`.
- Done pulse occurs in the cycle after the last write.
- `rst` has priority over everything, including mid-run; no write is issued in the reset cycle.
- Memory outputs are registered. `mem_addr` and `mem_wdata` hold their last values when `mem_we` = 0.

## Configuration
- `RLE_ERR_CHECK_EN` defined:
  - `decomp_err` port exists.
  - Set on an accepted zero-run word.
  - Set on truncation, meaning run remaining > 0 when pixel `IMG_PIXELS`-1 is written.
  - Cleared only by `rst` or by the `IDLE`→`FETCH` transition.
- Not defined: the port and its logic are absent. Zero runs are still silently skipped and truncation still occurs.

## Structure
- Package `rle_pkg`:
  - State enum.
  - Code-word field slice helpers.
  - Default `IMG_PIXELS`, `RUN_W` and `DATA_W` constants.
- One sub-module, `rle_run_counter`: a loadable down-counter with a zero flag, used for the remaining run. The FSM, pixel counter and memory registers stay in the top level.

## Test plan
- `IMG_PIXELS`=16: words {run 10, 0xAA}, {run 6, 0x55}.
  - Expected: addresses 0–9 written 0xAA and 10–15 written 0x55.
  - Done pulses one cycle after address 15, total 2 + 16 = 18 active cycles.
- `IMG_PIXELS`=16: single word {run 20, 0x33}.
  - Expected: exactly 16 writes, done pulse.
  - `decomp_err` = 1 with the macro; no port without it.
- Zero-run word {0, 0x77} followed by {run 16, 0x11}.
  - Expected: no 0x77 write; 16 writes of 0x11.
  - `decomp_err` = 1 with the macro.
- `in_valid` low for 5 cycles in `FETCH`.
  - Expected: `in_ready` stays 1, no writes, and the counter holds.
- Drop `decompressor_en` after 4 writes of a run, then reassert it.
  - Expected: writes stop on the next edge and there is no done pulse.
  - Restart begins at address 0.
- Hold `decompressor_en` high after done.
  - Expected: no second decode and no further done pulse until en toggles low then high.
- Assert `rst` mid-`EXPAND`.
  - Expected: all outputs return to 0 on the next edge and the state is `IDLE`.
